csr_btn: RTL and testbench
==========================

CSR_BTN -- requirements
Module: csr_btn

Interface
REQ-001 Parameter Addr, default 1: CSR address this block decodes.
REQ-002 Parameter DebounceCycles, default 16: stable cycles required before a level change is accepted; legal range 1..65535.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  CSR access strobe from decode.
REQ-006 addr  input  csr_addr_t  CSR address of current instruction.
REQ-007 rs1  input  r  source register/immediate field; zero suppresses write for set/clear ops.
REQ-008 rd  input  r  destination register field; ignored, since reads have no side effects.
REQ-009 op  input  csr_t  CSR operation (RW, RS, RC and immediate variants).
REQ-010 in  input  word  CSR write operand.
REQ-011 match  output  1  access targets this block.
REQ-012 out  output  word  CSR read data.
REQ-013 btn  input  1  asynchronous external button pin.

Function
REQ-014 match SHALL equal en && (addr == Addr), combinationally.
REQ-015 out SHALL be {29'b0, fall_pend, rise_pend, level} when match=1, else all zeros, combinationally from registers.
REQ-016 btn SHALL pass a 2-flop synchronizer (s1, s2) before any other use.
REQ-017 Debounce, each cycle:
- s2==level: cnt<=0.
- Else if cnt==DebounceCycles-1: level<=s2, cnt<=0.
- Otherwise: cnt<=cnt+1.
REQ-018 Pin change held stable SHALL appear in level exactly 2+DebounceCycles rising edges after the pin-sampling edge.
REQ-019 A glitch shorter than DebounceCycles cycles at s2 SHALL NOT change level; cnt SHALL restart from 0 on reversion.
REQ-020 On the edge level goes 0->1, rise_pend SHALL set; on 1->0, fall_pend SHALL set; both stay set until software clears them.
REQ-021 Write value SHALL be computed as new = in (RW), old|in (RS), old&~in (RC); immediate variants SHALL use zero-extended rs1 as in.
REQ-022 RS/RC/RSI/RCI with rs1==0 SHALL NOT write.
REQ-023 A write SHALL only clear pending bits: pend <= pend & new[2:1]; bit 0 and bits 31:3 are read-only and ignore writes.
REQ-024 Hardware set and software clear of the same pending bit in one cycle: set SHALL win.
REQ-025 Reads SHALL return pre-write values for the accessing instruction.

Reset
REQ-026 On reset assertion: s1, s2, level, cnt, rise_pend, fall_pend SHALL go to 0 immediately, regardless of clk.
REQ-027 Reset mid-debounce SHALL discard the count; no pending bit SHALL be set by reset release, even if btn=1.

Configuration
REQ-028 With CSR_BTN_DEBOUNCE_EN defined: debounce counter per REQ-017/018.
REQ-029 Without CSR_BTN_DEBOUNCE_EN: no counter; level<=s2 every cycle; latency 3 edges; DebounceCycles ignored.

Structure
REQ-030 csr_addr_t, csr_t, r, word SHALL come from decoder_pkg.
REQ-031 Bit positions LEVEL=0, RISE=1, FALL=2 SHALL be constants in decoder_pkg.
REQ-032 Synchronizer and debounce SHALL live in sub-module btn_debounce (clk, reset, pin -> level); csr_btn holds decode, pending flags and read mux.

Verification (Addr=1, DebounceCycles=4, debounce enabled unless noted)
REQ-033 btn 0->1 held -> level=1 exactly 6 edges later, rise_pend=1; read of addr 1 gives out=0x3, match=1.
REQ-034 btn pulse high for 3 cycles -> level stays 0, pending bits stay 0.
REQ-035 Pending set, CSRRC in=0x2 rs1=5 -> out before write 0x3, after 0x1; then CSRRS in=0x6 rs1=0 -> no change.
REQ-036 CSRRW in=0x0 on same cycle level falls -> fall_pend=1 after the edge (set wins), rise_pend=0.
REQ-037 reset asserted between clock edges while cnt=2 -> all outputs/state 0 before next edge; release with btn=1 -> no pending until level rises 6 edges after release.
REQ-038 Macro undefined: btn 0->1 -> level=1 after 3 edges; addr=0 access -> match=0, out=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared CSR decode types, CSR bit positions and CSR write helpers.
package decoder_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [4:0]  r;
  typedef logic [31:0] word;

  typedef enum logic [2:0] {
    CSR_NONE = 3'd0,
    CSR_RW   = 3'd1,
    CSR_RS   = 3'd2,
    CSR_RC   = 3'd3,
    CSR_RWI  = 3'd5,
    CSR_RSI  = 3'd6,
    CSR_RCI  = 3'd7
  } csr_t;

  // Bit positions of the button CSR fields
  localparam int unsigned LEVEL = 0;
  localparam int unsigned RISE  = 1;
  localparam int unsigned FALL  = 2;

  // Set/clear forms with a zero rs1 field are pure reads
  function automatic logic csr_writes(input csr_t op, input r rs1);
    unique case (op)
      CSR_RW, CSR_RWI:                  csr_writes = 1'b1;
      CSR_RS, CSR_RC, CSR_RSI, CSR_RCI: csr_writes = (rs1 != '0);
      default:                          csr_writes = 1'b0;
    endcase
  endfunction

  // New CSR value; immediate forms use the zero-extended rs1 field as operand
  function automatic word csr_apply(input csr_t op, input word old, input r rs1, input word in);
    word imm;
    imm = {27'b0, rs1};
    unique case (op)
      CSR_RW:  csr_apply = in;
      CSR_RS:  csr_apply = old | in;
      CSR_RC:  csr_apply = old & ~in;
      CSR_RWI: csr_apply = imm;
      CSR_RSI: csr_apply = old | imm;
      CSR_RCI: csr_apply = old & ~imm;
      default: csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button pin synchronizer and debouncer.
// Define CSR_BTN_DEBOUNCE_EN to enable the stability counter; otherwise the
// synchronized pin is copied to level every cycle and DebounceCycles is ignored.
module btn_debounce #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  logic s1;
  logic s2;

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef CSR_BTN_DEBOUNCE_EN
  localparam logic [15:0] CntMax = 16'(DebounceCycles - 1);

  logic [15:0] cnt;

  // Accept a new level only after it has been stable for DebounceCycles cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CntMax) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  localparam int unsigned unused_debounce_cycles = DebounceCycles;

  // Without debouncing the synchronized pin is the level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
    end else begin
      level <= s2;
    end
  end
`endif

endmodule

// File: rtl/csr_btn.sv
// Button CSR: address decode, sticky rise/fall pending flags and read mux.
// Debounce behaviour is selected by CSR_BTN_DEBOUNCE_EN (see btn_debounce).
module csr_btn
  import decoder_pkg::*;
#(
  parameter csr_addr_t   Addr           = 12'd1,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  csr_addr_t addr,
  input  r          rs1,
  input  r          rd,
  input  csr_t      op,
  input  word       in,
  output logic      match,
  output word       out,
  input  logic      btn
);

  logic level;
  logic level_prev;
  logic rise_pend;
  logic fall_pend;
  logic rise_eff;
  logic fall_eff;
  logic wr;
  word  cur;
  word  nxt;
  logic unused_bits;

  btn_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .pin  (btn),
    .level(level)
  );

  assign match = en && (addr == Addr);

  // An edge of level counts as pending from the edge it occurs on; the
  // registered flag absorbs it one cycle later, which makes the edge win over
  // a clear issued in the same cycle while a later clear still removes it.
  assign rise_eff = rise_pend | (level & ~level_prev);
  assign fall_eff = fall_pend | (~level & level_prev);

  assign unused_bits = ^{rd, nxt[31:3], nxt[LEVEL]};

  // Read mux and software write decode
  always_comb begin
    cur       = '0;
    cur[LEVEL] = level;
    cur[RISE]  = rise_eff;
    cur[FALL]  = fall_eff;
    out       = match ? cur : '0;
    wr        = match && csr_writes(op, rs1);
    nxt       = csr_apply(op, cur, rs1, in);
  end

  // Pending flags: software may only clear them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev <= 1'b0;
      rise_pend  <= 1'b0;
      fall_pend  <= 1'b0;
    end else begin
      level_prev <= level;
      rise_pend  <= rise_eff & (~wr | nxt[RISE]);
      fall_pend  <= fall_eff & (~wr | nxt[FALL]);
    end
  end

endmodule

// File: tb/tb_csr_btn.sv
// Self-checking bench for csr_btn with Addr=1, DebounceCycles=4.
module tb_csr_btn;
  import decoder_pkg::*;

  localparam int unsigned DC = 4;
`ifdef CSR_BTN_DEBOUNCE_EN
  localparam int unsigned W = DC;
`else
  localparam int unsigned W = 1;
`endif
  localparam int unsigned L = W + 2;

  logic      clk;
  logic      reset;
  logic      en;
  csr_addr_t addr;
  r          rs1;
  r          rd;
  csr_t      op;
  word       wdata;
  logic      match;
  word       out;
  logic      btn;

  int unsigned checks;
  int unsigned failures;

  // reference model: recent pin samples (newest first), level and sticky flags
  bit hist[$];
  bit mlevel;
  bit mrise;
  bit mfall;

  csr_btn #(
    .Addr(12'd1),
    .DebounceCycles(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .addr(addr),
    .rs1(rs1),
    .rd(rd),
    .op(op),
    .in(wdata),
    .match(match),
    .out(out),
    .btn(btn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < int'(L); i++) hist.push_back(1'b0);
    mlevel = 1'b0;
    mrise  = 1'b0;
    mfall  = 1'b0;
  endtask

  task automatic model_check(input string tag);
    bit mt;
    mt = en && (addr == 12'd1);
    check({tag, "_match"}, {31'b0, match}, {31'b0, mt});
    check({tag, "_out"}, out, mt ? {29'b0, mfall, mrise, mlevel} : 32'b0);
  endtask

  // One rising edge: advance the model from the current inputs, then compare
  task automatic tick(input string tag);
    bit flip, mt, wr, imm;
    bit [31:0] oldv, opnd, nv;
    mt = en && (addr == 12'd1);
    hist.push_front(btn);
    if (hist.size() > L) void'(hist.pop_back());
    // level follows once the W samples that reached s2 all disagree with it
    flip = 1'b1;
    for (int i = 2; i < int'(L); i++) if (hist[i] == mlevel) flip = 1'b0;
    oldv = {29'b0, mfall, mrise, mlevel};
    imm  = (op == CSR_RWI) || (op == CSR_RSI) || (op == CSR_RCI);
    opnd = imm ? {27'b0, rs1} : wdata;
    nv   = oldv;
    if (op == CSR_RW || op == CSR_RWI) nv = opnd;
    if (op == CSR_RS || op == CSR_RSI) nv = oldv | opnd;
    if (op == CSR_RC || op == CSR_RCI) nv = oldv & ~opnd;
    wr = mt && (op != CSR_NONE) && (op == CSR_RW || op == CSR_RWI || rs1 != 5'd0);
    if (wr) begin
      mrise = mrise & nv[1];
      mfall = mfall & nv[2];
    end
    if (flip) begin
      mlevel = ~mlevel;
      if (mlevel) mrise = 1'b1;
      else mfall = 1'b1;
    end
    @(posedge clk);
    #1;
    model_check(tag);
  endtask

  task automatic csr_idle();
    op = CSR_NONE; rs1 = '0; wdata = '0;
  endtask

  task automatic csr_clear_all();
    op = CSR_RW; rs1 = 5'd1; wdata = '0;
    tick("clear");
    csr_idle();
  endtask

  initial begin
    csr_t ops[7] = '{CSR_NONE, CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI};
    int unsigned run;
    checks = 0; failures = 0;
    reset = 1'b1; btn = 1'b0; en = 1'b1; addr = 12'd1; rd = '0;
    csr_idle();
    model_reset();
    #3;
    check("reset_out", out, 32'h0);
    check("reset_match", {31'b0, match}, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_check("post_reset");

    // rising press reaches level exactly L edges after the sampling edge
    btn = 1'b1;
    for (int k = 1; k <= int'(L); k++) begin
      tick("press");
      if (k == int'(L) - 1) check("press_early", out, 32'h0);
      if (k == int'(L)) check("press_level", out, 32'h3);
    end

    // release and a short glitch
    csr_clear_all();
    check("rise_cleared", out, 32'h1);
    btn = 1'b0;
    repeat (L) tick("release");
    check("release_level", out, 32'h4);
    csr_clear_all();
    btn = 1'b1;
    repeat (3) tick("glitch");
    btn = 1'b0;
    repeat (L + 2) tick("glitch_tail");
`ifdef CSR_BTN_DEBOUNCE_EN
    check("glitch_ignored", out, 32'h0);
`endif

    // clear-only writes, zero rs1 suppresses set/clear
    csr_clear_all();
    btn = 1'b1;
    repeat (L) tick("press2");
    op = CSR_RC; wdata = 32'h2; rs1 = 5'd5;
    #1;
    check("rc_pre", out, 32'h3);
    tick("rc");
    check("rc_post", out, 32'h1);
    op = CSR_RS; wdata = 32'h6; rs1 = 5'd0;
    tick("rs_zero");
    check("rs_zero_nochange", out, 32'h1);
    csr_idle();

    // clear in the same cycle the level falls: the hardware set wins
    btn = 1'b0;
    repeat (L - 1) tick("fall_wait");
    op = CSR_RW; wdata = 32'h0; rs1 = 5'd1;
    tick("set_wins");
    check("set_wins_out", out, 32'h4);
    csr_idle();

    // asynchronous reset mid-debounce, then release with the pin high
    csr_clear_all();
    btn = 1'b1;
    repeat (4) tick("pre_reset");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_out", out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (L - 1) tick("after_release");
    check("no_pend_on_release", out, 32'h0);
    tick("after_release_rise");
    check("rise_after_release", out, 32'h3);

    // decode: wrong address or no strobe
    addr = 12'd0;
    #1;
    check("addr0_match", {31'b0, match}, 32'h0);
    check("addr0_out", out, 32'h0);
    addr = 12'd1; en = 1'b0;
    #1;
    check("en0_out", out, 32'h0);
    en = 1'b1;

    // randomized pin runs, CSR traffic and occasional async resets
    run = 0;
    for (int c = 0; c < 600; c++) begin
      if (run == 0) begin
        btn = 1'($urandom);
        run = $urandom_range(1, 8);
      end
      run--;
      en   = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 3)) : 12'd1;
      op   = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 6)] : CSR_NONE;
      rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wdata = $urandom;
      rd   = 5'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        model_check("rand_reset");
        @(negedge clk);
        reset = 1'b0;
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
